// File: rtl/mem_stage_vl_pkg.sv
// Shared definitions for the LoongArch32 MS stage: bus widths, load opcodes
// and FSM state encoding.
package mem_stage_vl_pkg;

  localparam int ES_TO_MS_BUS_WD = 75;
  localparam int MS_TO_WS_BUS_WD = 70;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_H  = 3'd2;
  localparam logic [2:0] LD_BU = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

endpackage

// File: rtl/mem_stage_vl_ld_extend.sv
// Load data extraction: picks the byte/half lane addressed by addr[1:0]
// and sign- or zero-extends it. Misaligned halves are never presented.
module ld_extend
  import mem_stage_vl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr,
  input  logic [2:0]        ld_op,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select then extension by opcode
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (ld_op)
      LD_B:    result = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_BU:   result = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_H:    result = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LD_HU:   result = {{(DATA_W-16){1'b0}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_vl.sv
// MS stage with variable-latency data-sram responses. Holds one instruction,
// waits for its load/store response, extracts load data and forwards to ID.
// Responses that belong to flushed instructions are counted and discarded.
module mem_stage_vl
  import mem_stage_vl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32,
  parameter int DISC_W = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ms_flush,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [REG_AW-1:0]          ms_to_ds_dest,
  output logic [DATA_W-1:0]          ms_to_ds_result,
  output logic                       ms_to_ds_stall,
  input  logic                       data_sram_data_ok,
  input  logic [DATA_W-1:0]          data_sram_rdata
);

  // mem_req only steers the FSM on entry, so the held copy drops it
  localparam int HELD_W = ES_TO_MS_BUS_WD - 1;
  localparam logic [DISC_W-1:0] DISC_ONE = 1;

  ms_state_e          state;
  logic               ms_valid;
  logic [DISC_W-1:0]  disc_cnt;
  logic [HELD_W-1:0]  ms_bus_p0;
  logic [DATA_W-1:0]  rdata_buf_p1;

  logic [2:0]         ld_op;
  logic               res_from_mem;
  logic               gr_we;
  logic [REG_AW-1:0]  dest;
  logic [DATA_W-1:0]  alu_result;
  logic [PC_W-1:0]    pc;
  logic [DATA_W-1:0]  ld_result;
  logic [DATA_W-1:0]  final_result;

  logic      es_mem_req;
  logic      ready_go;
  logic      disc_full;
  logic      disc_idle;
  logic      accept;
  logic      own_ok;
  logic      disc_inc;
  logic      disc_dec;
  ms_state_e entry_state;

  assign {ld_op, res_from_mem, gr_we, dest, alu_result, pc} = ms_bus_p0;
  assign es_mem_req = es_to_ms_bus[ES_TO_MS_BUS_WD-1];

  assign ready_go    = (state == MS_DONE);
  assign disc_full   = &disc_cnt;
  assign disc_idle   = (disc_cnt == '0);
  // A flush in the same cycle must not swallow an instruction from EX
  assign ms_allowin  = (!ms_valid || (ready_go && ws_allowin)) && !disc_full && !ms_flush;
  assign accept      = es_to_ms_valid && ms_allowin;
  assign own_ok      = ms_valid && (state == MS_WAIT) && data_sram_data_ok && disc_idle;
  assign disc_inc    = ms_flush && ms_valid && (state == MS_WAIT) && !own_ok;
  assign disc_dec    = data_sram_data_ok && !disc_idle;
  assign entry_state = es_mem_req ? MS_WAIT : MS_DONE;

  // Per-instruction FSM; flush beats every other transition
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= MS_IDLE;
      ms_valid <= 1'b0;
    end else if (ms_flush) begin
      state    <= MS_IDLE;
      ms_valid <= 1'b0;
    end else begin
      case (state)
        MS_IDLE: if (accept) begin
          state    <= entry_state;
          ms_valid <= 1'b1;
        end
        MS_WAIT: if (own_ok) state <= MS_DONE;
        MS_DONE: if (ws_allowin) begin
          state    <= accept ? entry_state : MS_IDLE;
          ms_valid <= accept;
        end
        default: begin
          state    <= MS_IDLE;
          ms_valid <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding responses owed to cancelled instructions
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      disc_cnt <= '0;
    end else begin
      case ({disc_inc, disc_dec})
        2'b10:   disc_cnt <= disc_cnt + DISC_ONE;
        2'b01:   disc_cnt <= disc_cnt - DISC_ONE;
        default: disc_cnt <= disc_cnt;
      endcase
    end
  end

  // Instruction bus register, loaded on handshake with EX
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_bus_p0 <= '0;
    end else if (accept) begin
      ms_bus_p0 <= es_to_ms_bus[HELD_W-1:0];
    end
  end

  // Response capture; the result is always taken from here, never bypassed
  always_ff @(posedge clk) begin
    if (own_ok) rdata_buf_p1 <= data_sram_rdata;
  end

  ld_extend #(.DATA_W(DATA_W)) u_ld_extend (
    .rdata  (rdata_buf_p1),
    .addr   (alu_result[1:0]),
    .ld_op  (ld_op),
    .result (ld_result)
  );

  assign final_result    = res_from_mem ? ld_result : alu_result;
  assign ms_to_ws_valid  = ms_valid && ready_go;
  assign ms_to_ws_bus    = {gr_we, dest, final_result, pc};
  assign ms_to_ds_dest   = dest & {REG_AW{ms_valid && gr_we}};
  assign ms_to_ds_stall  = ms_valid && res_from_mem && (state == MS_WAIT);
  assign ms_to_ds_result = final_result;

endmodule
